fft32_slade_core: RTL and testbench

- Radix-2 decimation-in-time FFT core, default 32 points, 16-bit fixed-point Q1.15 complex data.
- Accepts N real samples serially and computes the transform in place, one butterfly per clock, using ping-pong RAM banks.
- Streams the N complex bins out serially in natural order.
- Internal sub-blocks: address-generation/control unit, combinational butterfly unit, twiddle ROM, two N-entry complex RAM banks.

---
 rtl/fft32_slade_core_if.sv | 13 +
 rtl/fft32_slade_core.sv | 194 +++++++++++++++++++
 tb/tb_fft32_slade_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fft32_slade_core_if.sv
// Streaming sample/bin bus of the FFT core: real samples in, complex bins out.
interface fft32_slade_core_if #(
  parameter int width = 16
);
  logic             start;
  logic             load;
  logic [width-1:0] rd;
  logic [2*width-1:0] wd;
  logic             done;

  modport master (output start, load, rd, input wd, done);
  modport slave  (input start, load, rd, output wd, done);
endinterface

// File: rtl/fft32_slade_core.sv
// In-place radix-2 DIT FFT: bit-reversed load into bank0, one butterfly per clock
// ping-ponging between two RAM banks, bins streamed out in natural order.
module fft32_slade_bfly #(
  parameter int width = 16
) (
  input  logic [2*width-1:0] a,
  input  logic [2*width-1:0] b,
  input  logic [2*width-1:0] w,
  output logic [2*width-1:0] aout,
  output logic [2*width-1:0] bout
);
  localparam int PW = 2*width + 1;

  logic signed [width-1:0] a_re, a_im, p_re, p_im;
  logic signed [PW-1:0]    b_re, b_im, w_re, w_im, acc_re, acc_im;

  // Floor of the Q-shifted product, low bits kept (wraps, no saturation).
  function automatic logic signed [width-1:0] prod_shift(input logic signed [PW-1:0] x);
    return width'(x >>> (width-1));
  endfunction

  always_comb begin
    a_re   = a[2*width-1:width];
    a_im   = a[width-1:0];
    b_re   = PW'($signed(b[2*width-1:width]));
    b_im   = PW'($signed(b[width-1:0]));
    w_re   = PW'($signed(w[2*width-1:width]));
    w_im   = PW'($signed(w[width-1:0]));
    acc_re = b_re * w_re - b_im * w_im;
    acc_im = b_re * w_im + b_im * w_re;
    p_re   = prod_shift(acc_re);
    p_im   = prod_shift(acc_im);
    aout   = {a_re + p_re, a_im + p_im};
    bout   = {a_re - p_re, a_im - p_im};
  end
endmodule

module fft32_slade_core #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic              clk,
  input  logic              reset,
  fft32_slade_core_if.slave bus
);
  localparam int N    = 1 << N_2;
  localparam int HALF = N / 2;
  localparam int SW   = $clog2(N_2 + 1);
  localparam int DW   = 2 * width;
  localparam logic [N_2-2:0] I_LAST = '1;
  localparam logic [SW-1:0]  S_LAST = SW'(N_2 - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t         state_q, state_d;
  logic [N_2-1:0] lcnt_q, lcnt_d, ocnt_q, ocnt_d;
  logic [SW-1:0]  s_q, s_d;
  logic [N_2-2:0] i_q, i_d;

  logic [DW-1:0] mem0_q [N];
  logic [DW-1:0] mem1_q [N];
  logic [DW-1:0] tw_rom [HALF];

  logic [N_2-1:0] adr_a, adr_b;
  logic [N_2-2:0] tw_mask;
  logic [DW-1:0]  op_a, op_b, op_w, res_a, res_b, out_word;
  logic           ld_we, bf_we;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic [DW-1:0] tw_entry(input int k);
    real amp, ang;
    int  cr, si;
    amp = real'((1 << (width-1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    cr  = rnd(amp * $cos(ang));
    si  = rnd(-amp * $sin(ang));
    return {cr[width-1:0], si[width-1:0]};
  endfunction

  function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] x);
    logic [N_2-1:0] r;
    for (int k = 0; k < N_2; k++) r[k] = x[N_2-1-k];
    return r;
  endfunction

  function automatic logic [N_2-1:0] rotl(input logic [N_2-1:0] x, input logic [SW-1:0] sh);
    logic [2*N_2-1:0] d;
    d = {x, x};
    d = d << sh;
    return d[2*N_2-1:N_2];
  endfunction

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam logic [DW-1:0] ENTRY = tw_entry(g);
    assign tw_rom[g] = ENTRY;
  end

  // Butterfly addressing: stage s reads bank s%2 and writes bank (s+1)%2.
  always_comb begin
    adr_a   = rotl({i_q, 1'b0}, s_q);
    adr_b   = rotl({i_q, 1'b1}, s_q);
    tw_mask = ~({(N_2-1){1'b1}} >> s_q);
    op_a    = s_q[0] ? mem1_q[adr_a] : mem0_q[adr_a];
    op_b    = s_q[0] ? mem1_q[adr_b] : mem0_q[adr_b];
    op_w    = tw_rom[i_q & tw_mask];
  end

  fft32_slade_bfly #(.width(width)) u_bfly (
    .a    (op_a),
    .b    (op_b),
    .w    (op_w),
    .aout (res_a),
    .bout (res_b)
  );

  assign ld_we = reset & bus.load;
  assign bf_we = reset & (state_q == COMPUTE) & ~bus.load & ~bus.start;

  always_ff @(posedge clk) begin
    if (ld_we) mem0_q[bitrev(lcnt_q)] <= {bus.rd, {width{1'b0}}};
    if (bf_we && s_q[0]) begin
      mem0_q[adr_a] <= res_a;
      mem0_q[adr_b] <= res_b;
    end
    if (bf_we && !s_q[0]) begin
      mem1_q[adr_a] <= res_a;
      mem1_q[adr_b] <= res_b;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = '0;
    s_d     = s_q;
    i_d     = i_q;
    ocnt_d  = ocnt_q;
    if (bus.load) begin
      state_d = IDLE;
      lcnt_d  = lcnt_q + N_2'(1);
      s_d     = '0;
      i_d     = '0;
      ocnt_d  = '0;
    end else if (bus.start) begin
      state_d = COMPUTE;
      s_d     = '0;
      i_d     = '0;
      ocnt_d  = '0;
    end else begin
      case (state_q)
        COMPUTE: begin
          if (i_q == I_LAST) begin
            i_d = '0;
            if (s_q == S_LAST) begin
              s_d     = '0;
              state_d = DONE;
            end else begin
              s_d = s_q + SW'(1);
            end
          end else begin
            i_d = i_q + (N_2-1)'(1);
          end
        end
        DONE:    ocnt_d = ocnt_q + N_2'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      s_q     <= '0;
      i_q     <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      s_q     <= s_d;
      i_q     <= i_d;
      ocnt_q  <= ocnt_d;
    end
  end

  // Final stage lands in bank N_2%2; bins are read straight out of it.
  always_comb begin
    out_word = (N_2 % 2 == 1) ? mem1_q[ocnt_q] : mem0_q[ocnt_q];
    bus.done = (state_q == DONE);
    bus.wd   = bus.done ? out_word : '0;
  end
endmodule

// File: tb/tb_fft32_slade_core.sv
// Directed-sequence bench for fft32_slade_core with random data against an array-based FFT model.
module tb_fft32_slade_core;
  localparam int W    = 16;
  localparam int N_2  = 5;
  localparam int N    = 32;
  localparam int HALF = 16;
  localparam int NBF  = 80;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft32_slade_core_if #(.width(W)) bus ();

  fft32_slade_core #(.width(W), .N_2(N_2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] bf_a, bf_b, bf_w, bf_ao, bf_bo;
  fft32_slade_bfly #(.width(W)) u_bf (
    .a    (bf_a),
    .b    (bf_b),
    .w    (bf_w),
    .aout (bf_ao),
    .bout (bf_bo)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [31:0]        m0 [N];
  logic [31:0]        m1 [N];
  logic [31:0]        tw [HALF];
  logic signed [15:0] smp [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic int bitrev(input int x);
    int r = 0;
    for (int b = 0; b < N_2; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  task automatic model_bf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                          output logic [31:0] ao, output logic [31:0] bo);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    wr = longint'($signed(w[31:16])); wi = longint'($signed(w[15:0]));
    pr = (br * wr - bi * wi) >>> 15;
    pi = (br * wi + bi * wr) >>> 15;
    ao = {16'(ar + pr), 16'(ai + pi)};
    bo = {16'(ar - pr), 16'(ai - pi)};
  endtask

  task automatic model_compute();
    logic [31:0] a, b, w, ao, bo;
    int ra, rb, xa, xb, msk;
    for (int s = 0; s < N_2; s++) begin
      for (int i = 0; i < HALF; i++) begin
        xa  = 2 * i;
        xb  = 2 * i + 1;
        ra  = ((xa << s) | (xa >> (N_2 - s))) % N;
        rb  = ((xb << s) | (xb >> (N_2 - s))) % N;
        msk = 15 & ~((1 << (N_2 - 1 - s)) - 1);
        w   = tw[i & msk];
        if (s % 2 == 0) begin
          a = m0[ra]; b = m0[rb];
          model_bf(a, b, w, ao, bo);
          m1[ra] = ao; m1[rb] = bo;
        end else begin
          a = m1[ra]; b = m1[rb];
          model_bf(a, b, w, ao, bo);
          m0[ra] = ao; m0[rb] = bo;
        end
      end
    end
  endtask

  task automatic load_samples();
    for (int k = 0; k < N; k++) begin
      bus.load = 1'b1;
      bus.rd   = smp[k];
      m0[bitrev(k)] = {smp[k], 16'h0000};
      @(negedge clk);
    end
    bus.load = 1'b0;
    bus.rd   = '0;
  endtask

  task automatic run_check(input string tag);
    int cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(NBF));
    model_compute();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_bin%0d", tag, k), bus.wd, m1[k]);
      @(negedge clk);
    end
    chk({tag, "_done_hold"}, 32'(bus.done), 32'd1);
    chk({tag, "_wrap_bin0"}, bus.wd, m1[0]);
  endtask

  initial begin
    logic [31:0] eao, ebo;
    logic        seen;
    for (int k = 0; k < HALF; k++)
      tw[k] = {16'(rnd(32767.0 * $cos(2.0 * 3.14159265358979323846 * k / N))),
               16'(rnd(-32767.0 * $sin(2.0 * 3.14159265358979323846 * k / N)))};

    reset = 1'b0;
    bus.start = 1'b0;
    bus.load  = 1'b0;
    bus.rd    = '0;
    bf_a = '0; bf_b = '0; bf_w = '0;
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_wd", bus.wd, 32'd0);
    reset = 1'b1;

    bf_a = 32'h0; bf_b = 32'h0; bf_w = 32'h7FFF_0000; #1;
    chk("bf0_a", bf_ao, 32'h0000_0000);
    chk("bf0_b", bf_bo, 32'h0000_0000);
    bf_a = 32'h0; bf_b = 32'h7FFF_0000; bf_w = 32'h7FFF_0000; #1;
    chk("bf1_a", bf_ao, 32'h7FFE_0000);
    chk("bf1_b", bf_bo, 32'h8002_0000);
    bf_a = 32'h1234_1234; bf_b = 32'h3FFF_3FFF; bf_w = 32'h471C_6A6C; #1;
    chk("bf2_a", bf_ao, 32'h008C_6AF6);
    chk("bf2_b", bf_bo, 32'h23DC_B972);
    for (int r = 0; r < 6; r++) begin
      bf_a = $urandom; bf_b = $urandom; bf_w = tw[$urandom_range(HALF-1)]; #1;
      model_bf(bf_a, bf_b, bf_w, eao, ebo);
      chk($sformatf("bfr%0d_a", r), bf_ao, eao);
      chk($sformatf("bfr%0d_b", r), bf_bo, ebo);
    end
    @(negedge clk);

    for (int k = 0; k < N; k++) smp[k] = '0;
    load_samples();
    run_check("zero");
    chk("zero_bin0_const", m1[0], 32'd0);

    for (int k = 0; k < N; k++) smp[k] = 16'($urandom);
    load_samples();
    run_check("rand");

    run_check("restart");

    for (int k = 0; k < N; k++) smp[k] = 16'($urandom_range(16'h7FFF)) - 16'sd16384;
    load_samples();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < N; k++) smp[k] = 16'($urandom);
    load_samples();
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_wd", bus.wd, 32'd0);
    run_check("reload");

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_wd", bus.wd, 32'd0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_idle", 32'(seen), 32'd0);
    run_check("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
